// File: rtl/imem_rd_pipe.sv
// Instruction memory read pipeline: word-addressed storage with a loader write port
// and a fixed-latency, in-order, killable read response path.
module imem_rd_pipe #(
  parameter int unsigned LATENCY              = 1,
  parameter int unsigned DEPTH_WORDS          = 4096,
  parameter int unsigned XLEN                 = 32,
  parameter int unsigned INSTR_MEM_WIDTH      = 32,
  parameter int unsigned INSTR_MEM_ADDR_WIDTH = 32,
  parameter int unsigned INSTR_MEM_TAG_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic                            req_valid,
  input  logic [XLEN-1:0]                 req_tag,
  input  logic                            kill,
  output logic [INSTR_MEM_WIDTH-1:0]      rsp_rdata,
  output logic                            rsp_valid,
  output logic [INSTR_MEM_TAG_WIDTH-1:0]  rsp_tag,
  output logic                            rsp_err,
  input  logic                            wr_en,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [INSTR_MEM_WIDTH-1:0]      wr_data
);

  localparam int unsigned IDX_W  = INSTR_MEM_ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [INSTR_MEM_WIDTH-1:0] NOP_WORD = INSTR_MEM_WIDTH'(32'h0000_0013);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_rd_pipe: LATENCY must be in 1..4");
  end

  logic [INSTR_MEM_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [MEM_AW-1:0] rd_midx, wr_midx;
  logic              rd_err, wr_ok;
  logic [INSTR_MEM_WIDTH-1:0] rd_word;

  logic                           vld_q [LATENCY];
  logic                           vld_d [LATENCY];
  logic                           err_q [LATENCY];
  logic                           err_d [LATENCY];
  logic [INSTR_MEM_TAG_WIDTH-1:0] tag_q [LATENCY];
  logic [INSTR_MEM_TAG_WIDTH-1:0] tag_d [LATENCY];
  logic [INSTR_MEM_WIDTH-1:0]     dat_q [LATENCY];
  logic [INSTR_MEM_WIDTH-1:0]     dat_d [LATENCY];

  always_comb begin
    rd_idx  = req_addr[INSTR_MEM_ADDR_WIDTH-1:2];
    wr_idx  = wr_addr[INSTR_MEM_ADDR_WIDTH-1:2];
    rd_midx = rd_idx[MEM_AW-1:0];
    wr_midx = wr_idx[MEM_AW-1:0];
    rd_err  = (req_addr[1:0] != 2'b00) || (64'(rd_idx) >= 64'(DEPTH_WORDS));
    wr_ok   = wr_en && (wr_addr[1:0] == 2'b00) && (64'(wr_idx) < 64'(DEPTH_WORDS));
    rd_word = rd_err ? NOP_WORD : mem_q[rd_midx];
  end

  // Data is captured at acceptance, so later writes never affect an in-flight read.
  // Payload stages only load behind a live valid, so outputs hold while rsp_valid=0.
  always_comb begin
    vld_d[0] = req_valid;
    err_d[0] = req_valid ? rd_err : err_q[0];
    tag_d[0] = req_valid ? INSTR_MEM_TAG_WIDTH'(req_tag) : tag_q[0];
    dat_d[0] = req_valid ? rd_word : dat_q[0];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1] && !kill;
      err_d[i] = vld_d[i] ? err_q[i-1] : err_q[i];
      tag_d[i] = vld_d[i] ? tag_q[i-1] : tag_q[i];
      dat_d[i] = vld_d[i] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        tag_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_midx] <= wr_data;
  end

  always_comb begin
    rsp_valid = vld_q[LATENCY-1] && !kill;
    rsp_err   = err_q[LATENCY-1];
    rsp_tag   = tag_q[LATENCY-1];
    rsp_rdata = dat_q[LATENCY-1];
  end

endmodule

// File: tb/tb_imem_rd_pipe.sv
// Directed bench driving LATENCY=2 and LATENCY=3 instances with shared stimulus;
// a per-instance queue holds expected responses with their due cycle.
module tb_imem_rd_pipe;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rst_n;
  logic [31:0] req_addr, req_tag, wr_addr, wr_data;
  logic        req_valid, kill, wr_en;

  logic [31:0] rd2, tg2, rd3, tg3;
  logic        v2, e2, v3, e3;

  imem_rd_pipe #(.LATENCY(2), .DEPTH_WORDS(DEPTH)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_valid(req_valid),
    .req_tag(req_tag), .kill(kill), .rsp_rdata(rd2), .rsp_valid(v2),
    .rsp_tag(tg2), .rsp_err(e2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  imem_rd_pipe #(.LATENCY(3), .DEPTH_WORDS(DEPTH)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_valid(req_valid),
    .req_tag(req_tag), .kill(kill), .rsp_rdata(rd3), .rsp_valid(v3),
    .rsp_tag(tg3), .rsp_err(e3), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] tag;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q [2][$];
  logic [31:0] refmem [int];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk(input int i, input int lat, input logic v, input logic [31:0] rd,
                     input logic [31:0] tg, input logic er);
    exp_t e;
    if (q[i].size() > 0 && q[i][0].due <= cyc) begin
      e = q[i].pop_front();
      cmp($sformatf("L%0d_valid", lat), {31'b0, v}, 32'd1);
      if (v) begin
        cmp($sformatf("L%0d_rdata", lat), rd, e.data);
        cmp($sformatf("L%0d_tag", lat), tg, e.tag);
        cmp($sformatf("L%0d_err", lat), {31'b0, er}, {31'b0, e.err});
      end
    end else begin
      cmp($sformatf("L%0d_spurious_valid", lat), {31'b0, v}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    chk(0, 2, v2, rd2, tg2, e2);
    chk(1, 3, v3, rd3, tg3, e3);
  end

  task automatic check_outputs_zero(input string tag);
    cmp({tag, "_L2_valid"}, {31'b0, v2}, 32'd0);
    cmp({tag, "_L2_err"},   {31'b0, e2}, 32'd0);
    cmp({tag, "_L2_rdata"}, rd2, 32'd0);
    cmp({tag, "_L2_tag"},   tg2, 32'd0);
    cmp({tag, "_L3_valid"}, {31'b0, v3}, 32'd0);
    cmp({tag, "_L3_err"},   {31'b0, e3}, 32'd0);
    cmp({tag, "_L3_rdata"}, rd3, 32'd0);
    cmp({tag, "_L3_tag"},   tg3, 32'd0);
  endtask

  // One cycle of stimulus; expected read data is taken before this cycle's write lands.
  task automatic step(input logic rv, input logic [31:0] a, input logic [31:0] t,
                      input logic k, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd);
    exp_t e;
    req_valid = rv; req_addr = a; req_tag = t; kill = k;
    wr_en = we; wr_addr = wa; wr_data = wd;
    if (k) begin
      q[0].delete();
      q[1].delete();
    end
    if (rv) begin
      e.err  = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
      e.data = e.err ? NOP : refmem[int'(a[31:2])];
      e.tag  = t;
      e.due  = cyc + 2; q[0].push_back(e);
      e.due  = cyc + 3; q[1].push_back(e);
    end
    if (we && wa[1:0] == 2'b00 && wa[31:2] < DEPTH) refmem[int'(wa[31:2])] = wd;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] t);
    step(1'b1, a, t, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, '0, '0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_tag = '0; kill = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Loader writes, including a misaligned and an out-of-range write that must be dropped
    wr(32'h0000_0000, 32'h0000_0093);
    wr(32'h0000_0004, 32'hAAAA_AAAA);
    wr(32'h0000_0008, 32'h1234_5678);
    wr(32'h0000_000C, 32'hDEAD_BEEF);
    wr(32'h0000_0010, 32'h00C0_FFEE);
    wr(32'h0000_0014, 32'h0BAD_F00D);
    wr(32'h0000_0006, 32'hFFFF_0006);
    wr(4 * DEPTH,     32'hFFFF_4000);
    idle(1);

    // Single read, then hold of response fields while idle
    rd(32'h0000_0000, 32'h8000_0000);
    idle(4);
    cmp("hold_L2_rdata", rd2, 32'h0000_0093);
    cmp("hold_L2_tag", tg2, 32'h8000_0000);

    // Back-to-back reads with distinct tags
    rd(32'h0000_0000, 32'h0000_1000);
    rd(32'h0000_0004, 32'h0000_1004);
    rd(32'h0000_0008, 32'h0000_1008);
    idle(4);

    // Misaligned and out-of-range reads, then storage around them unchanged
    rd(32'h0000_0002, 32'h0000_2002);
    rd(4 * DEPTH,     32'h0000_4000);
    rd(32'h0000_0000, 32'h0000_2000);
    rd(32'h0000_0004, 32'h0000_2004);
    idle(4);

    // Same-cycle read and write of one word, then read back
    step(1'b1, 32'h0000_0004, 32'h0000_3004, 1'b0, 1'b1, 32'h0000_0004, 32'h5555_5555);
    rd(32'h0000_0004, 32'h0000_3005);
    idle(4);

    // Write to a word while its read is in flight
    rd(32'h0000_0014, 32'h0000_5014);
    wr(32'h0000_0014, 32'h7777_7777);
    rd(32'h0000_0014, 32'h0000_5015);
    idle(4);

    // Redirect: two requests in flight, kill together with a new fetch
    rd(32'h0000_0008, 32'h0000_6008);
    rd(32'h0000_000C, 32'h0000_600C);
    step(1'b1, 32'h0000_0010, 32'h0000_6010, 1'b1, 1'b0, '0, '0);
    idle(5);

    // Reset with two requests in flight; retention and first-cycle acceptance after release
    rd(32'h0000_0000, 32'h0000_7000);
    rd(32'h0000_0008, 32'h0000_7008);
    q[0].delete();
    q[1].delete();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(32'h0000_0000, 32'hFFFF_FFF0);
    rd(32'h0000_0008, 32'hFFFF_FFF8);
    idle(6);

    cmp("L2_queue_drained", 32'(q[0].size()), 32'd0);
    cmp("L3_queue_drained", 32'(q[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
